// File: rtl/ihex_loader.sv
// ihex_loader: Intel HEX record decoder for the boot path.
// Takes ASCII characters from the UART rx FIFO, checks each record, and
// turns data records into byte write commands. It also captures the entry
// point and reports end-of-file or the first error.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for ':', all other characters dropped
// LEN     | collecting 2-digit data length
// ADDR    | collecting 4-digit load offset (big-endian)
// TYPE    | collecting 2-digit record type
// DATA    | collecting 2*LEN data digits into the record buffer
// CSUM    | collecting 2-digit checksum
// CHECK   | one cycle: verify sum, dispatch on record type
// EMIT    | issuing one write per buffered byte
// DONE    | EOF accepted; input drained until reset
// ERR     | error latched; input drained until reset
module ihex_loader #(
  parameter int MAX_LEN = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [31:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        wr_valid_o,
  input  logic        wr_ready_i,
  output logic [31:0] entry_addr_o,
  output logic        entry_valid_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  err_code_o
);

  // Buffer is never smaller than 4 so the fixed-index reads for type 04/05
  // stay in range; longer records are rejected by the length check anyway.
  localparam int BUF_D = (MAX_LEN < 4) ? 4 : MAX_LEN;
  localparam int IW    = (BUF_D > 1) ? $clog2(BUF_D) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [2:0] ERR_BAD_CHAR = 3'd1;
  localparam logic [2:0] ERR_LEN_OVF  = 3'd2;
  localparam logic [2:0] ERR_BAD_TYPE = 3'd3;
  localparam logic [2:0] ERR_CSUM     = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_LEN, S_ADDR, S_TYPE, S_DATA, S_CSUM, S_CHECK, S_EMIT, S_DONE, S_ERR
  } state_t;

  state_t      state;
  logic [3:0]  nib_hi;
  logic        have_nib;
  logic [7:0]  len;
  logic [15:0] addr;
  logic [7:0]  rtype;
  logic [7:0]  sum;
  logic [7:0]  idx;
  logic [15:0] ext_hi;
  logic [7:0]  rec_buf [BUF_D];

  logic        xfer;
  logic        is_hex;
  logic [3:0]  nib;
  logic [7:0]  byte_val;
  logic        buf_we;

  // Hex digit decode of the incoming character and byte assembly strobes.
  always_comb begin
    is_hex = 1'b0;
    nib    = 4'h0;
    if (in_data_i >= 8'h30 && in_data_i <= 8'h39) begin
      is_hex = 1'b1;
      nib    = in_data_i[3:0];
    end else if ((in_data_i >= 8'h41 && in_data_i <= 8'h46) ||
                 (in_data_i >= 8'h61 && in_data_i <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = in_data_i[3:0] + 4'd9;
    end
    xfer     = in_valid_i & in_ready_o;
    byte_val = {nib_hi, nib};
    buf_we   = xfer & is_hex & have_nib & (state == S_DATA);
  end

  // Record buffer; contents are only meaningful after a full DATA field.
  always_ff @(posedge clk_i) begin
    if (buf_we) rec_buf[IW'(idx)] <= byte_val;
  end

  // Record parser, checker and write emitter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= S_IDLE;
      nib_hi        <= 4'h0;
      have_nib      <= 1'b0;
      len           <= 8'h00;
      addr          <= 16'h0000;
      rtype         <= 8'h00;
      sum           <= 8'h00;
      idx           <= 8'h00;
      ext_hi        <= 16'h0000;
      in_ready_o    <= 1'b1;
      wr_addr_o     <= 32'h0;
      wr_data_o     <= 8'h00;
      wr_valid_o    <= 1'b0;
      entry_addr_o  <= 32'h0;
      entry_valid_o <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      err_code_o    <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (xfer && in_data_i == 8'h3A) begin
            state    <= S_LEN;
            sum      <= 8'h00;
            idx      <= 8'h00;
            have_nib <= 1'b0;
          end
        end

        S_LEN, S_ADDR, S_TYPE, S_DATA, S_CSUM: begin
          if (xfer) begin
            if (!is_hex) begin
              state      <= S_ERR;
              err_o      <= 1'b1;
              err_code_o <= ERR_BAD_CHAR;
            end else if (!have_nib) begin
              nib_hi   <= nib;
              have_nib <= 1'b1;
            end else begin
              have_nib <= 1'b0;
              sum      <= sum + byte_val;
              case (state)
                S_LEN: begin
                  len <= byte_val;
                  if (byte_val > MAX_LEN_B) begin
                    state      <= S_ERR;
                    err_o      <= 1'b1;
                    err_code_o <= ERR_LEN_OVF;
                  end else begin
                    state <= S_ADDR;
                    idx   <= 8'h00;
                  end
                end
                S_ADDR: begin
                  addr <= {addr[7:0], byte_val};
                  if (idx[0]) begin
                    state <= S_TYPE;
                    idx   <= 8'h00;
                  end else begin
                    idx <= idx + 8'd1;
                  end
                end
                S_TYPE: begin
                  rtype <= byte_val;
                  state <= (len == 8'h00) ? S_CSUM : S_DATA;
                end
                S_DATA: begin
                  idx <= idx + 8'd1;
                  if (idx == len - 8'd1) state <= S_CSUM;
                end
                default: begin
                  // Final checksum byte: hold input off while the record is judged.
                  state      <= S_CHECK;
                  in_ready_o <= 1'b0;
                end
              endcase
            end
          end
        end

        S_CHECK: begin
          in_ready_o <= 1'b1;
          state      <= S_IDLE;
          if (sum != 8'h00) begin
            state      <= S_ERR;
            err_o      <= 1'b1;
            err_code_o <= ERR_CSUM;
          end else begin
            case (rtype)
              8'h00: begin
                if (len != 8'h00) begin
                  state      <= S_EMIT;
                  in_ready_o <= 1'b0;
                  wr_valid_o <= 1'b1;
                  wr_addr_o  <= {ext_hi, addr};
                  wr_data_o  <= rec_buf[0];
                  idx        <= 8'h00;
                end
              end
              8'h01: begin
                if (len == 8'h00) begin
                  state  <= S_DONE;
                  done_o <= 1'b1;
                end else begin
                  state      <= S_ERR;
                  err_o      <= 1'b1;
                  err_code_o <= ERR_BAD_TYPE;
                end
              end
              8'h04: begin
                if (len == 8'h02) begin
                  ext_hi <= {rec_buf[0], rec_buf[1]};
                end else begin
                  state      <= S_ERR;
                  err_o      <= 1'b1;
                  err_code_o <= ERR_BAD_TYPE;
                end
              end
              8'h05: begin
                if (len == 8'h04) begin
                  entry_addr_o  <= {rec_buf[0], rec_buf[1], rec_buf[2], rec_buf[3]};
                  entry_valid_o <= 1'b1;
                end else begin
                  state      <= S_ERR;
                  err_o      <= 1'b1;
                  err_code_o <= ERR_BAD_TYPE;
                end
              end
              default: begin
                state      <= S_ERR;
                err_o      <= 1'b1;
                err_code_o <= ERR_BAD_TYPE;
              end
            endcase
          end
        end

        S_EMIT: begin
          if (wr_ready_i) begin
            if (idx == len - 8'd1) begin
              wr_valid_o <= 1'b0;
              in_ready_o <= 1'b1;
              state      <= S_IDLE;
            end else begin
              idx              <= idx + 8'd1;
              // Low half wraps within the 64 KiB segment; ext_hi is untouched.
              wr_addr_o[15:0]  <= wr_addr_o[15:0] + 16'd1;
              wr_data_o        <= rec_buf[IW'(idx + 8'd1)];
            end
          end
        end

        default: begin
          // DONE and ERR keep draining input with in_ready_o high.
          in_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ihex_loader.sv
// Directed bench for ihex_loader: boot image, backpressure, error codes,
// segment wrap and reset during write emission.
module tb_ihex_loader;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [7:0]  in_data_i = 8'h00;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] wr_addr_o;
  logic [7:0]  wr_data_o;
  logic        wr_valid_o;
  logic        wr_ready_i = 1'b1;
  logic [31:0] entry_addr_o;
  logic        entry_valid_o;
  logic        done_o;
  logic        err_o;
  logic [2:0]  err_code_o;

  ihex_loader #(.MAX_LEN(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .in_data_i    (in_data_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .wr_valid_o   (wr_valid_o),
    .wr_ready_i   (wr_ready_i),
    .entry_addr_o (entry_addr_o),
    .entry_valid_o(entry_valid_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .err_code_o   (err_code_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic bp_mode = 1'b0;

  logic [31:0] log_addr[$];
  logic [7:0]  log_data[$];
  int          log_cyc[$];
  int          stall_viol = 0;
  int          stall_seen = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [7:0]  prev_data = 8'h00;

  logic [7:0] boot_bytes [16] = '{8'h37, 8'hC5, 8'h01, 8'h00, 8'h13, 8'h05, 8'h25, 8'hF5,
                                  8'h13, 8'h00, 8'h00, 8'h00, 8'h67, 8'h80, 8'h00, 8'h00};

  always @(posedge clk) cyc++;

  // Backpressure pattern: ready flips once per cycle, away from the edge.
  always @(posedge clk) begin
    if (bp_mode) begin
      #2;
      wr_ready_i = ~wr_ready_i;
    end
  end

  // Write monitor: logs handshakes and checks hold-during-stall.
  always @(negedge clk) begin
    if (!rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!wr_valid_o || wr_addr_o !== prev_addr || wr_data_o !== prev_data))
        stall_viol++;
      if (wr_valid_o && wr_ready_i) begin
        log_addr.push_back(wr_addr_o);
        log_data.push_back(wr_data_o);
        log_cyc.push_back(cyc);
      end
      prev_stall = wr_valid_o && !wr_ready_i;
      if (prev_stall) stall_seen++;
      prev_addr = wr_addr_o;
      prev_data = wr_data_o;
    end
  end

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    stall_viol = 0;
    stall_seen = 0;
  endtask

  task automatic do_reset();
    bp_mode    = 1'b0;
    @(negedge clk);
    rst_i      = 1'b0;
    in_valid_i = 1'b0;
    wr_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    clear_logs();
    rst_i = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the character transferred.
  task automatic send_char(input logic [7:0] c);
    int t;
    t = 0;
    in_data_i  = c;
    in_valid_i = 1'b1;
    while (!in_ready_o && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_char: in_ready_o stuck low for char %h", c);
    end
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic send_rec(input string s);
    send_str(s);
    send_char(8'h0D);
    send_char(8'h0A);
  endtask

  task automatic send_boot();
    send_rec(":0200000480106A");
    send_rec(":1000000037C50100130525F51300000067800000C7");
    send_rec(":040000058010000067");
    send_rec(":00000001FF");
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({in_ready_o, wr_valid_o, entry_valid_o, done_o, err_o, err_code_o} !== 8'b1000_0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 10000000",
               {in_ready_o, wr_valid_o, entry_valid_o, done_o, err_o, err_code_o});
    end
    n_cmp++;
    if ({wr_addr_o, wr_data_o, entry_addr_o} !== 72'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h %h %h want 0", wr_addr_o, wr_data_o, entry_addr_o);
    end
  endtask

  task automatic check_boot_writes(input string tag);
    n_cmp++;
    if (log_addr.size() != 16) begin
      n_bad++;
      $display("FAIL %s_count: got %0d writes want 16", tag, log_addr.size());
    end
    for (int i = 0; i < 16 && i < log_addr.size(); i++) begin
      n_cmp++;
      if (log_addr[i] !== 32'h8010_0000 + 32'(i) || log_data[i] !== boot_bytes[i]) begin
        n_bad++;
        $display("FAIL %s_write[%0d]: got %h@%h want %h@%h", tag, i, log_data[i], log_addr[i],
                 boot_bytes[i], 32'h8010_0000 + 32'(i));
      end
    end
    n_cmp++;
    if (entry_addr_o !== 32'h8010_0000 || entry_valid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_entry: got %h v=%b want 80100000 v=1", tag, entry_addr_o, entry_valid_o);
    end
    n_cmp++;
    if (done_o !== 1'b1 || err_o !== 1'b0 || err_code_o !== 3'd0) begin
      n_bad++;
      $display("FAIL %s_status: got done=%b err=%b code=%0d want 1 0 0", tag, done_o, err_o, err_code_o);
    end
  endtask

  task automatic test_boot_image();
    do_reset();
    send_boot();
    repeat (4) @(negedge clk);
    check_boot_writes("boot");
    if (log_cyc.size() == 16) begin
      n_cmp++;
      if (log_cyc[15] - log_cyc[0] != 15) begin
        n_bad++;
        $display("FAIL boot_rate: got %0d cycles want 15", log_cyc[15] - log_cyc[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bp_mode = 1'b1;
    send_boot();
    repeat (4) @(negedge clk);
    bp_mode = 1'b0;
    repeat (2) @(negedge clk);
    wr_ready_i = 1'b1;
    check_boot_writes("bp");
    n_cmp++;
    if (stall_viol != 0 || stall_seen == 0) begin
      n_bad++;
      $display("FAIL bp_hold: got violations=%0d stalls=%0d want 0 and >0", stall_viol, stall_seen);
    end
  endtask

  task automatic test_csum_fault();
    do_reset();
    send_rec(":0100000011EF");
    n_cmp++;
    if (err_o !== 1'b1 || err_code_o !== 3'd4 || log_addr.size() != 0) begin
      n_bad++;
      $display("FAIL csum_err: got err=%b code=%0d writes=%0d want 1 4 0", err_o, err_code_o,
               log_addr.size());
    end
    send_boot();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (log_addr.size() != 0 || err_code_o !== 3'd4 || entry_valid_o !== 1'b0 || done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL csum_sticky: got writes=%0d code=%0d ev=%b done=%b want 0 4 0 0",
               log_addr.size(), err_code_o, entry_valid_o, done_o);
    end
  endtask

  task automatic test_bad_char();
    do_reset();
    send_str(":0");
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL badchar_pre: got err=%b want 0", err_o);
    end
    send_char("G");
    n_cmp++;
    if (err_o !== 1'b1 || err_code_o !== 3'd1 || in_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL badchar: got err=%b code=%0d rdy=%b want 1 1 1", err_o, err_code_o, in_ready_o);
    end
  endtask

  task automatic test_ovf_type();
    do_reset();
    send_str(":11");
    n_cmp++;
    if (err_o !== 1'b1 || err_code_o !== 3'd2) begin
      n_bad++;
      $display("FAIL len_ovf: got err=%b code=%0d want 1 2", err_o, err_code_o);
    end
    do_reset();
    send_rec(":00000002FE");
    n_cmp++;
    if (err_o !== 1'b1 || err_code_o !== 3'd3 || done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_type: got err=%b code=%0d done=%b want 1 3 0", err_o, err_code_o, done_o);
    end
  endtask

  task automatic test_wrap_reset();
    int t;
    do_reset();
    send_rec(":0200000480106A");
    send_str(":02FFFF00AABB9B");
    n_cmp++;
    if (in_ready_o !== 1'b0 || wr_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL check_cycle: got rdy=%b wv=%b want 0 0", in_ready_o, wr_valid_o);
    end
    @(negedge clk);
    n_cmp++;
    if (wr_valid_o !== 1'b1 || wr_addr_o !== 32'h8010_FFFF || wr_data_o !== 8'hAA) begin
      n_bad++;
      $display("FAIL emit_first: got wv=%b %h@%h want 1 aa@8010ffff", wr_valid_o, wr_data_o, wr_addr_o);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (log_addr.size() != 2) begin
      n_bad++;
      $display("FAIL wrap_count: got %0d want 2", log_addr.size());
    end else begin
      n_cmp++;
      if (log_addr[1] !== 32'h8010_0000 || log_data[1] !== 8'hBB) begin
        n_bad++;
        $display("FAIL wrap_addr: got %h@%h want bb@80100000", log_data[1], log_addr[1]);
      end
    end
    n_cmp++;
    if (in_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_emit: got %b want 1", in_ready_o);
    end

    // Reset while a write is stalled in EMIT.
    wr_ready_i = 1'b0;
    send_str(":040000001122334452");
    t = 0;
    while (!wr_valid_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (wr_valid_o !== 1'b1 || wr_data_o !== 8'h11) begin
      n_bad++;
      $display("FAIL emit_stall: got wv=%b data=%h want 1 11", wr_valid_o, wr_data_o);
    end
    #2;
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if (wr_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL async_reset: got wv=%b rdy=%b want 0 1", wr_valid_o, in_ready_o);
    end
    repeat (2) @(negedge clk);
    clear_logs();
    wr_ready_i = 1'b1;
    rst_i = 1'b1;
    @(negedge clk);
    send_rec(":01001000559A");
    repeat (2) @(negedge clk);
    n_cmp++;
    if (log_addr.size() != 1) begin
      n_bad++;
      $display("FAIL post_reset_count: got %0d want 1", log_addr.size());
    end else begin
      n_cmp++;
      if (log_addr[0] !== 32'h0000_0010 || log_data[0] !== 8'h55) begin
        n_bad++;
        $display("FAIL post_reset_write: got %h@%h want 55@00000010", log_data[0], log_addr[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_boot_image();
    test_backpressure();
    test_csum_fault();
    test_bad_char();
    test_ovf_type();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ihex_loader.md
# ihex_loader

Hardware Intel HEX record decoder for the boot path. It consumes the ASCII byte stream that the UART receive FIFO delivers, validates each record, and emits byte-wide memory write commands toward the DDR-backed load region. It also reports the program entry point and end-of-file to the CPU reset/boot controller. It sits between the UART rx FIFO read port and the boot memory write port.

## Interface
- MAX_LEN, 16: largest accepted record data length in bytes; sets the depth of the record buffer (1..255).
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-low reset.
- in_data_i  in  8  ASCII character from the rx FIFO.
- in_valid_i  in  1  in_data_i valid.
- in_ready_o  out  1  loader accepts a character this cycle; transfer when valid & ready.
- wr_addr_o  out  32  byte write address.
- wr_data_o  out  8  byte write data.
- wr_valid_o  out  1  write command valid.
- wr_ready_i  in  1  memory accepts the write.
- entry_addr_o  out  32  start linear address from the type-05 record.
- entry_valid_o  out  1  entry_addr_o loaded; sticky.
- done_o  out  1  EOF record accepted; sticky.
- err_o  out  1  error seen; sticky.
- err_code_o  out  3  1 BAD_CHAR, 2 LEN_OVF, 3 BAD_TYPE, 4 CSUM; 0 when err_o=0.

## Operation
- States: IDLE, LEN, ADDR, TYPE, DATA, CSUM, CHECK, EMIT, DONE, ERR.
- IDLE: discard every character except ':'. A ':' goes to LEN and clears the running sum and byte index. CR, LF and spaces between records are discarded here.
- Hex digits: '0'-'9', 'A'-'F' and 'a'-'f' are accepted. In LEN/ADDR/TYPE/DATA/CSUM, any other character sets error code BAD_CHAR and goes to ERR.
- Field order: 2 digits LEN, 4 digits ADDR (big-endian), 2 digits TYPE, 2×LEN digits DATA, 2 digits CSUM.
  - Each completed byte is added mod 256 to the running sum.
  - When LEN = 0, TYPE goes straight to CSUM.
- LEN > MAX_LEN: checked when the LEN byte completes; sets LEN_OVF and goes to ERR.
- DATA: bytes are stored in a MAX_LEN-entry buffer at the byte index.
- CHECK (one cycle):
  - Sum ≠ 0: CSUM error.
  - Otherwise, by TYPE:
    - 00 → EMIT; LEN = 0 → IDLE.
    - 01 with LEN = 0 → DONE.
    - 04 with LEN = 2 → ext_hi ← {buf0, buf1}, go to IDLE.
    - 05 with LEN = 4 → entry_addr_o ← {buf0..buf3}, entry_valid_o ← 1, go to IDLE.
    - Any other type, or a wrong LEN for 01/04/05 → BAD_TYPE.
- EMIT: byte i has wr_addr_o = {ext_hi, (ADDR + i) mod 2^16}, so the low half wraps and ext_hi is unchanged. wr_data_o = buf[i]. After the last byte is accepted, go to IDLE.
- Side effects only after checksum pass: a record that fails the checksum causes no write and no ext_hi or entry update.
- DONE and ERR: terminal until reset. in_ready_o = 1 and all input is discarded, so the FIFO drains. ERR keeps the first error code.
- ext_hi resets to 0x0000.

## Timing
- Reset values:
  - in_ready_o = 1.
  - wr_valid_o, entry_valid_o, done_o, err_o = 0.
  - wr_addr_o, wr_data_o, entry_addr_o = 0; err_code_o = 0; state = IDLE.
- Reset is asserted asynchronously and released synchronously to clk_i. Reset during EMIT drops wr_valid_o immediately.
- in_ready_o = 1 in every state except CHECK and EMIT. Throughput is one character per cycle.
- CHECK is the cycle after the final CSUM digit transfers.
- done_o, err_o, entry_valid_o and new ext_hi are visible the cycle after CHECK.
- wr_valid_o rises the cycle after CHECK.
  - wr_addr_o and wr_data_o stay stable while wr_valid_o=1 and wr_ready_i=0.
  - With wr_ready_i held high, one byte is written per cycle, so a LEN=N record takes N EMIT cycles.
  - in_ready_o returns high the cycle after the last handshake.
- in_valid_i low in any state: no state change and no partial-digit loss.
- Registered outputs only; no combinational path from in_valid_i to in_ready_o or from wr_ready_i to wr_valid_o.

## Test plan
- Boot image: stream ":0200000480106A", ":1000000037C50100130525F51300000067800000C7", ":040000058010000067", ":00000001FF", each with CRLF, wr_ready_i=1.
  - Exactly 16 writes: 0x37@0x80100000, 0xC5@0x80100001, …, 0x00@0x8010000F.
  - entry_addr_o = 0x80100000 with entry_valid_o=1; done_o=1; err_o=0.
- Backpressure: same image with wr_ready_i toggling every other cycle → identical 16 writes in order; address/data held during stalls.
- Checksum fault: ":0100000011EF" (correct checksum is EE) → no write; err_o=1; err_code_o=4. Subsequent valid records are ignored.
- Bad character: ":0G" → err_code_o=1 on the cycle after 'G'; in_ready_o stays 1.
- Overflow/type: with MAX_LEN=16, a LEN=0x11 record gives err_code_o=2; ":00000002FE" gives err_code_o=3.
- Wrap and reset: ext_hi=0x8010, then a 2-byte record at ADDR 0xFFFF → writes at 0x8010FFFF and 0x80100000. Asserting rst_i mid-EMIT clears wr_valid_o at once and returns to IDLE.
